// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared serializer state encoding and UART defaults
package uart_pkg;

  localparam int DEFAULT_CYCLES_PER_BIT = 104;
  localparam int BITS_PER_BYTE          = 8;
  localparam int BYTES_PER_WORD         = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/word_fifo.sv
// rtl/word_fifo.sv - power-of-two word FIFO with registered count and show-ahead read
module word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (!do_push && do_pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/word_uart_tx.sv
// rtl/word_uart_tx.sv - buffered 32-bit word to 8N1 UART transmitter, MSB byte first
module word_uart_tx
  import uart_pkg::*;
#(
  parameter int CYCLES_PER_BIT = DEFAULT_CYCLES_PER_BIT,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] word_in,
  input  logic        word_valid,
  output logic        word_ready,
  output logic        tx_out,
  output logic        busy,
  output logic        word_sent
);

  localparam int                CNT_W    = $clog2(CYCLES_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [2:0]        BIT_LAST = 3'(BITS_PER_BYTE - 1);
  localparam logic [1:0]        BYTE_LAST = 2'(BYTES_PER_WORD - 1);

  tx_state_e                   state_q;
  logic [CNT_W-1:0]            cnt_q;
  logic [2:0]                  bit_q;
  logic [1:0]                  byte_q;
  logic [31:0]                 word_q;
  logic                        tx_q;
  logic                        busy_q;
  logic                        sent_q;
  logic                        en_q;

  logic                        fifo_push;
  logic                        fifo_pop;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [31:0]                 fifo_dout;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  logic                        bit_end;
  logic                        word_end;
  logic [7:0]                  cur_byte;
  logic                        line_d;

  word_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (word_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // en_q keeps ready low through reset and the first edge after release.
  assign word_ready = en_q & ~fifo_full;
  assign fifo_push  = word_valid & word_ready;

  assign bit_end  = (cnt_q == CNT_LAST);
  assign word_end = (state_q == STOP) && bit_end && (byte_q == BYTE_LAST);
  assign fifo_pop = ~fifo_empty & ((state_q == IDLE) | word_end);
  assign cur_byte = word_q[31:24];

  always_comb begin
    line_d = 1'b1;
    case (state_q)
      START:   line_d = 1'b0;
      DATA:    line_d = cur_byte[bit_q];
      default: line_d = 1'b1;
    endcase
  end

  assign tx_out    = tx_q;
  assign busy      = busy_q;
  assign word_sent = sent_q;

  // Line, busy and word_sent all trail the state by one cycle, so frame
  // timing on the pins stays exact and word_sent lines up with the stop bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      word_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      sent_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      en_q   <= 1'b1;
      tx_q   <= line_d;
      busy_q <= (state_q != IDLE) || (fifo_count != '0);
      sent_q <= word_end;

      case (state_q)
        IDLE: begin
          cnt_q  <= '0;
          bit_q  <= '0;
          byte_q <= '0;
          if (!fifo_empty) begin
            state_q <= START;
            word_q  <= fifo_dout;
          end
        end

        START: begin
          if (bit_end) begin
            state_q <= DATA;
            cnt_q   <= '0;
            bit_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_q == BIT_LAST) begin
              state_q <= STOP;
              bit_q   <= '0;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        STOP: begin
          if (bit_end) begin
            cnt_q <= '0;
            bit_q <= '0;
            if (byte_q == BYTE_LAST) begin
              byte_q <= '0;
              if (!fifo_empty) begin
                state_q <= START;
                word_q  <= fifo_dout;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              state_q <= START;
              byte_q  <= byte_q + 1'b1;
              word_q  <= {word_q[23:0], 8'h00};
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/word_uart_tx.md
WORD_UART_TX -- requirements
Module: word_uart_tx

Interface
REQ-001 SHALL have parameter CYCLES_PER_BIT, default 104, meaning clock cycles per UART bit.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of 32-bit words buffered; power of two, at least 2.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port word_in  input  32  word to transmit.
REQ-007 SHALL have port word_valid  input  1  word_in is valid this cycle.
REQ-008 SHALL have port word_ready  output  1  the FIFO can accept a word; equals not full.
REQ-009 SHALL have port tx_out  output  1  UART serial line, idle high.
REQ-010 SHALL have port busy  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-011 SHALL have port word_sent  output  1  one-cycle pulse at the end of the stop bit of a word's fourth byte.

Function
REQ-012 SHALL accept a word on a rising edge where word_valid and word_ready are both high; a word with word_valid high and word_ready low is ignored, not queued.
REQ-013 SHALL derive word_ready only from the registered FIFO count, so a pop in the same cycle does not admit a push while full.
REQ-014 SHALL serialize each word as 4 bytes, most-significant byte first (word[31:24] first, word[7:0] last).
REQ-015 SHALL frame each byte as 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), each held for exactly CYCLES_PER_BIT cycles.
REQ-016 SHALL use serializer states IDLE, START, DATA, STOP: IDLE->START when the FIFO is non-empty (pop word); START->DATA after one bit time; DATA->STOP after 8 bits; STOP->START for bytes 0-2; STOP->START for the next word if the FIFO is non-empty after byte 3; otherwise STOP->IDLE.
REQ-017 SHALL insert no idle gap between consecutive bytes or words; a 4-byte word occupies exactly 40*CYCLES_PER_BIT cycles.
REQ-018 SHALL drive the start bit (tx_out low) beginning 2 cycles after the accepting edge when the block is IDLE with an empty FIFO.
REQ-019 SHALL pop the FIFO only on the IDLE->START transition or the STOP->START transition between words, never mid-word.
REQ-020 SHALL preserve FIFO order, with read and write pointers wrapping modulo FIFO_DEPTH.
REQ-021 SHALL hold tx_out high in IDLE and STOP.
REQ-022 SHALL pulse word_sent in the last cycle of the stop bit of byte 3.
REQ-023 SHALL use a bit-time counter, bit index (0-7) and byte index (0-3), each reset to 0 on every state entry as appropriate.

Reset
REQ-024 SHALL, on rst_n low and at any time including mid-frame, immediately force: tx_out=1, word_ready=0, busy=0, word_sent=0, state=IDLE, FIFO empty, all counters 0.
REQ-025 SHALL raise word_ready on the first rising edge after rst_n deasserts; no partial frame resumes.

Structure
REQ-026 SHALL import the state enum (IDLE, START, DATA, STOP) and the default CYCLES_PER_BIT constant from the shared package uart_pkg.
REQ-027 SHALL instantiate one sub-module, word_fifo (parameterized width 32 and depth FIFO_DEPTH, with push/pop/full/empty/count).

Verification
REQ-028 SHALL test a single word: push 0xDEADBEEF while idle -> line bytes DE, AD, BE, EF at 104 cycles/bit, start bit 2 cycles after accept, one word_sent pulse 4160 cycles after the start bit.
REQ-029 SHALL test back-to-back words: push 0x01020304 and 0xA5A5A5A5 on consecutive cycles -> 8 contiguous frames with no idle cycle, then two word_sent pulses.
REQ-030 SHALL test FIFO full: while transmitting, push 5 words -> 4 words queued and word_ready low; the 5th word (word_valid held with ready low) is dropped unless it is re-presented after ready rises.
REQ-031 SHALL test reset mid-frame: assert rst_n low during bit 3 of byte 1 -> tx_out=1 within the same cycle, FIFO empty; after release, a new push of 0x00000000 transmits cleanly.
REQ-032 SHALL test wrap-around: stream 10 distinct words in sequence -> received in order, pointers wrap correctly, busy falls only after the last stop bit.
REQ-033 SHALL test loopback: connect tx_out to uart_rx feeding word_rx -> word_out equals each transmitted word.
